rc_signal_monitor: RTL and testbench
====================================

Name: rc_signal_monitor

Overview:
- Sits directly downstream of the 6-channel RC pulse-capture stage. Consumes its per-channel pulse widths and its ch1 period, all in 1 us LSBs.
- Qualifies each RC frame, tracks link health in a 3-state machine, and presents held, range-checked channel values plus failsafe values to the flight-control register file.
- Runs on the same clk, with the same 1 MHz pwm_clk one-cycle strobe as the capture stage.

Parameters:
- WORDSIZE, 15: width of every pulse/period bus.
- WIDTH_MIN, 900: minimum legal channel width (us).
- WIDTH_MAX, 2100: maximum legal channel width (us).
- PERIOD_MIN, 10000: minimum legal frame period (us).
- PERIOD_MAX, 30000: maximum legal frame period (us).
- GOOD_FRAMES, 4: number of consecutive good frames needed to enter VALID.
- BAD_FRAMES, 3: number of consecutive bad frames in VALID before FAILSAFE.
- TIMEOUT_US, 50000: number of pwm_clk ticks without a ch1 rising edge before timeout.
- FS_WIDTH, 1500: failsafe value for ch1, ch2, ch4, ch5, ch6.
- FS_THROTTLE, 1000: failsafe value for ch3.
- DEADBAND, 4: used only with RC_DEADBAND_EN.

Ports:
- clk, in, 1: system clock (24 MHz).
- rst_n, in, 1: asynchronous active-low reset.
- pwm_clk, in, 1: 1 MHz single-clk-cycle strobe. All logic advances only when it is high.
- rc_en, in, 1: enable. 0 forces ACQUIRE.
- pwm_in_ch1, in, 1: raw ch1 RC input, used for frame timing.
- pulse_width_ch1..ch6, in, WORDSIZE each: widths from the capture stage.
- pulse_period, in, WORDSIZE: ch1 period from the capture stage.
- ch_out1..ch_out6, out, WORDSIZE each: qualified channel values.
- rc_valid, out, 1: high only in VALID.
- failsafe, out, 1: high in ACQUIRE and FAILSAFE.
- frame_err, out, 1: one-clk pulse when a frame is judged bad.

Behaviour:
- Reset values:
  - state = ACQUIRE, rc_valid = 0, failsafe = 1, frame_err = 0.
  - ch_out1, 2, 4, 5, 6 = FS_WIDTH; ch_out3 = FS_THROTTLE.
  - Internal regs: good_cnt = 0, bad_cnt = 0, timeout_cnt = 0, armed = 0, eval_pending = 0.
- Input sync and edge detect:
  - pwm_in_ch1 passes through a 3-flop chain s1 -> s2 -> s3, clocked on pwm_clk.
  - Rising edge = s2 & ~s3. This matches the capture stage's edge tick.
- Evaluation timing:
  - An edge sets eval_pending.
  - The frame is evaluated on the next pwm_clk tick, because pulse_period and the widths have settled by then.
  - Evaluation clears eval_pending.
- Arming:
  - The first edge after reset, a timeout, or rc_en=0 only sets armed. That frame is not evaluated.
  - Evaluation happens only if armed = 1.
- Good frame: PERIOD_MIN <= pulse_period <= PERIOD_MAX, and every width is within [WIDTH_MIN, WIDTH_MAX], inclusive. All comparisons are unsigned.
- Bad frame: anything else. frame_err pulses for one clk.
- Timeout counter:
  - timeout_cnt clears on every edge and increments on each pwm_clk tick otherwise, saturating.
  - Reaching TIMEOUT_US is a timeout event.
  - On timeout: armed = 0, good_cnt = 0, and the counter stays saturated until the next edge.
- ACQUIRE state:
  - Good frame: good_cnt++. When good_cnt reaches GOOD_FRAMES, go to VALID, load ch_outN from pulse_width_chN, clear good_cnt.
  - Bad frame: good_cnt = 0.
  - Timeout: stay in ACQUIRE.
- VALID state:
  - Good frame: update ch_outN and clear bad_cnt.
  - Bad frame: bad_cnt++ and hold ch_out. When bad_cnt reaches BAD_FRAMES, go to FAILSAFE.
  - Timeout: go to FAILSAFE immediately.
- FAILSAFE state:
  - On entry, ch_out are loaded with the failsafe values.
  - Good frames count as in ACQUIRE. Reaching GOOD_FRAMES goes to VALID and loads the widths.
  - Bad frame: good_cnt = 0.
- rc_en = 0 (sampled on pwm_clk):
  - State = ACQUIRE, all counters cleared, armed = 0, eval_pending = 0, ch_out = failsafe values.
  - rc_en has priority over evaluation and timeout.
- Simultaneous events:
  - An evaluation and a timeout on the same tick cannot occur, because the edge clears the counter.
  - A new edge on the evaluation tick re-sets eval_pending.
- Output timing: outputs change one clk after the evaluating pwm_clk tick. rc_valid and failsafe are registered decodes of state.
- Async reset mid-frame returns everything to the reset values immediately.

Optional Feature:
- Macro: RC_DEADBAND_EN.
- When defined: in VALID, ch_outN updates on a good frame only if |pulse_width_chN - ch_outN| > DEADBAND. Each channel is checked independently. Loads on entering VALID are unconditional.
- When undefined: every good frame updates all channels. The DEADBAND parameter is ignored.

Test Plan:
- 20 ms frames with all widths at 1500: after the arming edge plus 4 good frames -> rc_valid = 1, failsafe = 0, all ch_out = 1500.
- In VALID, set ch2 to 2200 for 2 frames, then 1600: ch_out2 holds 1500 with two frame_err pulses, bad_cnt clears, then ch_out2 = 1600 and the state stays VALID.
- In VALID, three consecutive frames with pulse_period = 8000 -> FAILSAFE, ch_out3 = 1000, others = 1500, rc_valid = 0.
- In VALID, stop pwm_in_ch1 for 50000 pwm_clk ticks -> FAILSAFE on the timeout tick. After restart: 1 arming edge plus 4 good frames -> VALID.
- Drop rc_en for 1 tick while in VALID -> ACQUIRE, failsafe values. Re-enable: reacquires after arming plus 4 frames.
- With RC_DEADBAND_EN: ch1 changes 1500 -> 1503 leaves ch_out1 = 1500; 1500 -> 1505 sets ch_out1 = 1505. Boundary widths 900 and 2100 are good; 899 and 2101 are bad.

Source files
------------

// File: rtl/rc_signal_monitor.sv
// RC link monitor: qualifies capture-stage frames, tracks link health
// (ACQUIRE/VALID/FAILSAFE) and presents held or failsafe channel values.
// Ports: clk, rst_n (async low), pwm_clk strobe, rc_en, pwm_in_ch1,
//   pulse_width_ch1..6 / pulse_period in; ch_out1..6, rc_valid,
//   failsafe, frame_err out. Optional macro: RC_DEADBAND_EN.
module rc_signal_monitor #(
  parameter int WORDSIZE    = 15,
  parameter int WIDTH_MIN   = 900,
  parameter int WIDTH_MAX   = 2100,
  parameter int PERIOD_MIN  = 10000,
  parameter int PERIOD_MAX  = 30000,
  parameter int GOOD_FRAMES = 4,
  parameter int BAD_FRAMES  = 3,
  parameter int TIMEOUT_US  = 50000,
  parameter int FS_WIDTH    = 1500,
  parameter int FS_THROTTLE = 1000,
  parameter int DEADBAND    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwm_clk,
  input  logic                rc_en,
  input  logic                pwm_in_ch1,
  input  logic [WORDSIZE-1:0] pulse_width_ch1,
  input  logic [WORDSIZE-1:0] pulse_width_ch2,
  input  logic [WORDSIZE-1:0] pulse_width_ch3,
  input  logic [WORDSIZE-1:0] pulse_width_ch4,
  input  logic [WORDSIZE-1:0] pulse_width_ch5,
  input  logic [WORDSIZE-1:0] pulse_width_ch6,
  input  logic [WORDSIZE-1:0] pulse_period,
  output logic [WORDSIZE-1:0] ch_out1,
  output logic [WORDSIZE-1:0] ch_out2,
  output logic [WORDSIZE-1:0] ch_out3,
  output logic [WORDSIZE-1:0] ch_out4,
  output logic [WORDSIZE-1:0] ch_out5,
  output logic [WORDSIZE-1:0] ch_out6,
  output logic                rc_valid,
  output logic                failsafe,
  output logic                frame_err
);

  localparam int GW = $clog2(GOOD_FRAMES + 1);
  localparam int BW = $clog2(BAD_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_US + 1);

  localparam logic [WORDSIZE-1:0] WMIN = WORDSIZE'(WIDTH_MIN);
  localparam logic [WORDSIZE-1:0] WMAX = WORDSIZE'(WIDTH_MAX);
  localparam logic [WORDSIZE-1:0] PMIN = WORDSIZE'(PERIOD_MIN);
  localparam logic [WORDSIZE-1:0] PMAX = WORDSIZE'(PERIOD_MAX);
  localparam logic [WORDSIZE-1:0] FS_W = WORDSIZE'(FS_WIDTH);
  localparam logic [WORDSIZE-1:0] FS_T = WORDSIZE'(FS_THROTTLE);
  localparam logic [GW-1:0]       GOOD_N = GW'(GOOD_FRAMES);
  localparam logic [BW-1:0]       BAD_N  = BW'(BAD_FRAMES);
  localparam logic [TW-1:0]       TO_N   = TW'(TIMEOUT_US);
  localparam logic [TW-1:0]       TO_LAST = TW'(TIMEOUT_US - 1);

`ifdef RC_DEADBAND_EN
  localparam logic [WORDSIZE-1:0] DB_T = WORDSIZE'(DEADBAND);
`else
  // zero threshold: an equal width is a no-op load, so all channels follow
  localparam logic [WORDSIZE-1:0] DB_T = WORDSIZE'(DEADBAND * 0);
`endif

  typedef enum logic [1:0] {
    ACQUIRE  = 2'd0,
    VALID    = 2'd1,
    FAILSAFE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;
  logic [TW-1:0] to_q, to_d;
  logic          armed_q, armed_d;
  logic          pend_q, pend_d;
  logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic          ferr_q, ferr_d;
  logic          valid_q, valid_d;
  logic          fs_q, fs_d;

  logic [WORDSIZE-1:0] w    [6];
  logic [WORDSIZE-1:0] ch_q [6];
  logic [WORDSIZE-1:0] ch_d [6];
  logic [WORDSIZE-1:0] diff;
  logic [5:0]          upd;
  logic                frame_ok;
  logic                rise;
  logic                eval;
  logic                tmo;

  assign w[0] = pulse_width_ch1;
  assign w[1] = pulse_width_ch2;
  assign w[2] = pulse_width_ch3;
  assign w[3] = pulse_width_ch4;
  assign w[4] = pulse_width_ch5;
  assign w[5] = pulse_width_ch6;

  assign ch_out1   = ch_q[0];
  assign ch_out2   = ch_q[1];
  assign ch_out3   = ch_q[2];
  assign ch_out4   = ch_q[3];
  assign ch_out5   = ch_q[4];
  assign ch_out6   = ch_q[5];
  assign rc_valid  = valid_q;
  assign failsafe  = fs_q;
  assign frame_err = ferr_q;

  // same edge tick as the capture stage
  assign rise = s2_q & ~s3_q;
  assign eval = pend_q & armed_q;
  assign tmo  = ~rise & (to_q == TO_LAST);

  function automatic logic [WORDSIZE-1:0] fs_val(input int i);
    return (i == 2) ? FS_T : FS_W;
  endfunction

  always_comb begin
    frame_ok = (pulse_period >= PMIN) && (pulse_period <= PMAX);
    diff     = '0;
    upd      = '0;
    for (int i = 0; i < 6; i++) begin
      if (w[i] < WMIN || w[i] > WMAX) frame_ok = 1'b0;
      diff   = (w[i] >= ch_q[i]) ? w[i] - ch_q[i] : ch_q[i] - w[i];
      upd[i] = diff > DB_T;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACQUIRE;
      good_q  <= '0;
      bad_q   <= '0;
      to_q    <= '0;
      armed_q <= 1'b0;
      pend_q  <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
      fs_q    <= 1'b1;
      for (int i = 0; i < 6; i++) ch_q[i] <= fs_val(i);
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      to_q    <= to_d;
      armed_q <= armed_d;
      pend_q  <= pend_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      for (int i = 0; i < 6; i++) ch_q[i] <= ch_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    to_d    = to_q;
    armed_d = armed_q;
    pend_d  = pend_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    s3_d    = s3_q;
    ferr_d  = 1'b0;
    for (int i = 0; i < 6; i++) ch_d[i] = ch_q[i];
    if (pwm_clk) begin
      s1_d = pwm_in_ch1;
      s2_d = s1_q;
      s3_d = s2_q;
      if (!rc_en) begin
        state_d = ACQUIRE;
        good_d  = '0;
        bad_d   = '0;
        to_d    = '0;
        armed_d = 1'b0;
        pend_d  = 1'b0;
        for (int i = 0; i < 6; i++) ch_d[i] = fs_val(i);
      end else begin
        // the arming edge sets armed only; it is never evaluated
        pend_d = rise & armed_q;
        if (rise) begin
          to_d    = '0;
          armed_d = 1'b1;
        end else if (to_q != TO_N) begin
          to_d = to_q + TW'(1);
        end
        if (tmo) begin
          armed_d = 1'b0;
          good_d  = '0;
          if (state_q == VALID) begin
            state_d = FAILSAFE;
            bad_d   = '0;
            for (int i = 0; i < 6; i++) ch_d[i] = fs_val(i);
          end
        end else if (eval) begin
          ferr_d = ~frame_ok;
          case (state_q)
            VALID: begin
              if (frame_ok) begin
                bad_d = '0;
                for (int i = 0; i < 6; i++)
                  if (upd[i]) ch_d[i] = w[i];
              end else if (bad_q + BW'(1) == BAD_N) begin
                state_d = FAILSAFE;
                bad_d   = '0;
                for (int i = 0; i < 6; i++) ch_d[i] = fs_val(i);
              end else begin
                bad_d = bad_q + BW'(1);
              end
            end
            default: begin
              if (!frame_ok) begin
                good_d = '0;
              end else if (good_q + GW'(1) == GOOD_N) begin
                state_d = VALID;
                good_d  = '0;
                bad_d   = '0;
                for (int i = 0; i < 6; i++) ch_d[i] = w[i];
              end else begin
                good_d = good_q + GW'(1);
              end
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    valid_d = (state_q == VALID);
    fs_d    = (state_q != VALID);
  end

endmodule

// File: tb/tb_rc_signal_monitor.sv
// Directed bench for rc_signal_monitor: acquisition, frame checks,
// failsafe paths, timeout, enable, strobe gating, reset, deadband.
module tb_rc_signal_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_clk = 1'b1;
  logic        rc_en = 1'b1;
  logic        pwm_in = 1'b0;
  logic [14:0] w1, w2, w3, w4, w5, w6, period;
  logic [14:0] o1, o2, o3, o4, o5, o6;
  logic        rc_valid, failsafe, frame_err;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int fe0;

  rc_signal_monitor dut (
    .clk(clk), .rst_n(rst_n), .pwm_clk(pwm_clk), .rc_en(rc_en),
    .pwm_in_ch1(pwm_in),
    .pulse_width_ch1(w1), .pulse_width_ch2(w2), .pulse_width_ch3(w3),
    .pulse_width_ch4(w4), .pulse_width_ch5(w5), .pulse_width_ch6(w6),
    .pulse_period(period),
    .ch_out1(o1), .ch_out2(o2), .ch_out3(o3),
    .ch_out4(o4), .ch_out5(o5), .ch_out6(o6),
    .rc_valid(rc_valid), .failsafe(failsafe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err) fe_cnt <= fe_cnt + 1;

  task automatic set_all(input logic [14:0] v);
    w1 = v; w2 = v; w3 = v; w4 = v; w5 = v; w6 = v;
  endtask

  task automatic run_frame();
    @(negedge clk) pwm_in = 1'b1;
    repeat (5) @(negedge clk);
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    set_all(15'd1500);
    period = 15'd20000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rc_valid); end
    checks++; if (failsafe !== 1'b1) begin errors++; $display("FAIL reset_fs got %b want 1", failsafe); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    checks++; if (o1 !== 15'd1500) begin errors++; $display("FAIL reset_ch1 got %0d want 1500", o1); end
    checks++; if (o3 !== 15'd1000) begin errors++; $display("FAIL reset_ch3 got %0d want 1000", o3); end
  endtask

  task automatic test_acquire();
    repeat (4) run_frame();
    checks++; if (rc_valid !== 1'b0) begin errors++; $display("FAIL acq_early got %b want 0", rc_valid); end
    run_frame();
    checks++; if (rc_valid !== 1'b1) begin errors++; $display("FAIL acq_valid got %b want 1", rc_valid); end
    checks++; if (failsafe !== 1'b0) begin errors++; $display("FAIL acq_fs got %b want 0", failsafe); end
    checks++; if (o3 !== 15'd1500) begin errors++; $display("FAIL acq_ch3 got %0d want 1500", o3); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL acq_ferr got %0d want 0", fe_cnt); end
  endtask

  task automatic test_bad_width();
    fe0 = fe_cnt;
    w2 = 15'd2200;
    repeat (2) run_frame();
    checks++; if (o2 !== 15'd1500) begin errors++; $display("FAIL bw_hold got %0d want 1500", o2); end
    checks++; if (fe_cnt - fe0 !== 2) begin errors++; $display("FAIL bw_ferr got %0d want 2", fe_cnt - fe0); end
    w2 = 15'd1600;
    run_frame();
    checks++; if (o2 !== 15'd1600) begin errors++; $display("FAIL bw_upd got %0d want 1600", o2); end
    w2 = 15'd2200;
    repeat (2) run_frame();
    checks++; if (rc_valid !== 1'b1) begin errors++; $display("FAIL bw_badclr got %b want 1", rc_valid); end
    w2 = 15'd1600;
    run_frame();
  endtask

  task automatic test_distinct();
    w1 = 15'd1111; w2 = 15'd1222; w3 = 15'd1333;
    w4 = 15'd1444; w5 = 15'd1555; w6 = 15'd1666;
    run_frame();
    checks++; if (o1 !== 15'd1111) begin errors++; $display("FAIL dist_ch1 got %0d want 1111", o1); end
    checks++; if (o2 !== 15'd1222) begin errors++; $display("FAIL dist_ch2 got %0d want 1222", o2); end
    checks++; if (o3 !== 15'd1333) begin errors++; $display("FAIL dist_ch3 got %0d want 1333", o3); end
    checks++; if (o4 !== 15'd1444) begin errors++; $display("FAIL dist_ch4 got %0d want 1444", o4); end
    checks++; if (o5 !== 15'd1555) begin errors++; $display("FAIL dist_ch5 got %0d want 1555", o5); end
    checks++; if (o6 !== 15'd1666) begin errors++; $display("FAIL dist_ch6 got %0d want 1666", o6); end
  endtask

  task automatic test_boundary();
    fe0 = fe_cnt;
    set_all(15'd1500);
    w1 = 15'd900; w6 = 15'd2100; period = 15'd10000;
    run_frame();
    checks++; if (o1 !== 15'd900) begin errors++; $display("FAIL bnd_900 got %0d want 900", o1); end
    checks++; if (o6 !== 15'd2100) begin errors++; $display("FAIL bnd_2100 got %0d want 2100", o6); end
    period = 15'd30000;
    run_frame();
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL bnd_good got %0d want 0", fe_cnt - fe0); end
    w1 = 15'd899; run_frame();
    checks++; if (o1 !== 15'd900) begin errors++; $display("FAIL bnd_899 got %0d want 900", o1); end
    w1 = 15'd900; run_frame();
    w6 = 15'd2101; run_frame();
    checks++; if (o6 !== 15'd2100) begin errors++; $display("FAIL bnd_2101 got %0d want 2100", o6); end
    w6 = 15'd2100; run_frame();
    period = 15'd9999; run_frame();
    period = 15'd20000; run_frame();
    period = 15'd30001; run_frame();
    period = 15'd20000; run_frame();
    checks++; if (fe_cnt - fe0 !== 4) begin errors++; $display("FAIL bnd_bad got %0d want 4", fe_cnt - fe0); end
    checks++; if (rc_valid !== 1'b1) begin errors++; $display("FAIL bnd_valid got %b want 1", rc_valid); end
  endtask

  task automatic test_deadband();
    logic [14:0] exp;
    set_all(15'd1500);
    run_frame();
    checks++; if (o1 !== 15'd1500) begin errors++; $display("FAIL db_base got %0d want 1500", o1); end
    w1 = 15'd1503;
    run_frame();
`ifdef RC_DEADBAND_EN
    exp = 15'd1500;
`else
    exp = 15'd1503;
`endif
    checks++; if (o1 !== exp) begin errors++; $display("FAIL db_1503 got %0d want %0d", o1, exp); end
    w1 = 15'd1505;
    run_frame();
    checks++; if (o1 !== 15'd1505) begin errors++; $display("FAIL db_1505 got %0d want 1505", o1); end
  endtask

  task automatic test_period_failsafe();
    fe0 = fe_cnt;
    set_all(15'd1500);
    w1 = 15'd1234;
    run_frame();
    period = 15'd8000;
    repeat (2) run_frame();
    checks++; if (rc_valid !== 1'b1) begin errors++; $display("FAIL pf_two got %b want 1", rc_valid); end
    run_frame();
    checks++; if (rc_valid !== 1'b0) begin errors++; $display("FAIL pf_valid got %b want 0", rc_valid); end
    checks++; if (failsafe !== 1'b1) begin errors++; $display("FAIL pf_fs got %b want 1", failsafe); end
    checks++; if (o3 !== 15'd1000) begin errors++; $display("FAIL pf_ch3 got %0d want 1000", o3); end
    checks++; if (o1 !== 15'd1500) begin errors++; $display("FAIL pf_ch1 got %0d want 1500", o1); end
    checks++; if (fe_cnt - fe0 !== 3) begin errors++; $display("FAIL pf_ferr got %0d want 3", fe_cnt - fe0); end
    period = 15'd20000;
    repeat (3) run_frame();
    checks++; if (rc_valid !== 1'b0) begin errors++; $display("FAIL pf_early got %b want 0", rc_valid); end
    run_frame();
    checks++; if (rc_valid !== 1'b1) begin errors++; $display("FAIL pf_recov got %b want 1", rc_valid); end
    checks++; if (o1 !== 15'd1234) begin errors++; $display("FAIL pf_load got %0d want 1234", o1); end
  endtask

  task automatic test_rc_en();
    @(negedge clk) rc_en = 1'b0;
    @(negedge clk) rc_en = 1'b1;
    @(negedge clk);
    checks++; if (rc_valid !== 1'b0) begin errors++; $display("FAIL en_valid got %b want 0", rc_valid); end
    checks++; if (o1 !== 15'd1500) begin errors++; $display("FAIL en_ch1 got %0d want 1500", o1); end
    checks++; if (o3 !== 15'd1000) begin errors++; $display("FAIL en_ch3 got %0d want 1000", o3); end
    repeat (4) run_frame();
    checks++; if (rc_valid !== 1'b0) begin errors++; $display("FAIL en_early got %b want 0", rc_valid); end
    run_frame();
    checks++; if (rc_valid !== 1'b1) begin errors++; $display("FAIL en_recov got %b want 1", rc_valid); end
  endtask

  task automatic test_strobe_gate();
    fe0 = fe_cnt;
    @(negedge clk) pwm_clk = 1'b0;
    w1 = 15'd2500;
    repeat (3) run_frame();
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL sg_ferr got %0d want 0", fe_cnt - fe0); end
    checks++; if (rc_valid !== 1'b1) begin errors++; $display("FAIL sg_valid got %b want 1", rc_valid); end
    checks++; if (o1 !== 15'd1234) begin errors++; $display("FAIL sg_ch1 got %0d want 1234", o1); end
    w1 = 15'd1234;
    pwm_clk = 1'b1;
    run_frame();
  endtask

  task automatic test_async_reset();
    @(negedge clk) pwm_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (rc_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", rc_valid); end
    checks++; if (failsafe !== 1'b1) begin errors++; $display("FAIL ar_fs got %b want 1", failsafe); end
    checks++; if (o1 !== 15'd1500) begin errors++; $display("FAIL ar_ch1 got %0d want 1500", o1); end
    @(negedge clk) pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) run_frame();
    checks++; if (rc_valid !== 1'b1) begin errors++; $display("FAIL ar_recov got %b want 1", rc_valid); end
  endtask

  task automatic test_timeout();
    repeat (49980) @(negedge clk);
    checks++; if (rc_valid !== 1'b1) begin errors++; $display("FAIL to_early got %b want 1", rc_valid); end
    repeat (30) @(negedge clk);
    checks++; if (rc_valid !== 1'b0) begin errors++; $display("FAIL to_valid got %b want 0", rc_valid); end
    checks++; if (failsafe !== 1'b1) begin errors++; $display("FAIL to_fs got %b want 1", failsafe); end
    checks++; if (o1 !== 15'd1500) begin errors++; $display("FAIL to_ch1 got %0d want 1500", o1); end
    checks++; if (o3 !== 15'd1000) begin errors++; $display("FAIL to_ch3 got %0d want 1000", o3); end
    repeat (4) run_frame();
    checks++; if (rc_valid !== 1'b0) begin errors++; $display("FAIL to_rearm got %b want 0", rc_valid); end
    run_frame();
    checks++; if (rc_valid !== 1'b1) begin errors++; $display("FAIL to_recov got %b want 1", rc_valid); end
    checks++; if (o1 !== 15'd1234) begin errors++; $display("FAIL to_load got %0d want 1234", o1); end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_bad_width();
    test_distinct();
    test_boundary();
    test_deadband();
    test_period_failsafe();
    test_rc_en();
    test_strobe_gate();
    test_async_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
